// File: rtl/pea_cfg_loader.sv
// pea_cfg_loader: unpacks 32-bit config words into two 16-bit PE config writes, row-major over the PEA.
module pea_cfg_loader #(
    parameter int N_BITS        = 32,
    parameter int N_CFG_BITS_PE = 16,
    parameter int M             = 4,
    parameter int N             = 4,
    localparam int LOG_M        = $clog2(M),
    localparam int LOG_N        = $clog2(N),
    localparam int CW           = LOG_M + LOG_N
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     word_valid_i,
    input  logic [N_BITS-1:0]        word_i,
    output logic                     word_ready_o,
    output logic                     cfg_we_o,
    output logic [CW-1:0]            cfg_pe_idx_o,
    output logic [N_CFG_BITS_PE-1:0] cfg_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LO, S_HI, S_DONE} state_t;

    localparam logic [CW-1:0] LAST   = CW'(M * N - 1);
    localparam logic [3:0]    OP_MAX = 4'd12;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d, idx_q, idx_d;
    logic [N_CFG_BITS_PE-1:0] hi_q, hi_d, data_q, data_d;
    logic                     err_q, err_d;
    logic                     legal;

    assign legal        = data_q[3:0] <= OP_MAX;
    assign cfg_pe_idx_o = idx_q;
    assign cfg_data_o   = data_q;
    assign err_o        = err_q;
    assign busy_o       = state_q != S_IDLE;
    assign word_ready_o = state_q == S_WAIT;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Data/idx registers are loaded on entry to LO/HI so the write appears in that state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        data_d   = data_q;
        err_d    = err_q;
        cfg_we_o = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_WAIT;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            S_WAIT: if (word_valid_i) begin
                state_d = S_LO;
                hi_d    = word_i[N_BITS-1:N_CFG_BITS_PE];
                data_d  = word_i[N_CFG_BITS_PE-1:0];
                idx_d   = cnt_q;
            end
            S_LO: begin
                cfg_we_o = legal;
                err_d    = err_q | ~legal;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == LAST) ? S_DONE : S_HI;
                data_d   = (cnt_q == LAST) ? data_q : hi_q;
                idx_d    = (cnt_q == LAST) ? idx_q : cnt_q + CW'(1);
            end
            S_HI: begin
                cfg_we_o = legal;
                err_d    = err_q | ~legal;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == LAST) ? S_DONE : S_WAIT;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything: drops any in-flight word and write, keeps err.
        if (abort_i && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = idx_q;
            hi_d     = hi_q;
            data_d   = data_q;
            err_d    = err_q;
            cfg_we_o = 1'b0;
            done_o   = 1'b0;
        end
    end
endmodule

// File: tb/tb_pea_cfg_loader.sv
// tb_pea_cfg_loader: directed self-checking bench for the PEA config loader.
module tb_pea_cfg_loader;
    logic        clk_i = 1'b0;
    logic        rst_n_i, start_i, abort_i, word_valid_i;
    logic [31:0] word_i;
    logic        word_ready_o, cfg_we_o, busy_o, done_o, err_o;
    logic [3:0]  cfg_pe_idx_o;
    logic [15:0] cfg_data_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dones = 0;
    int done_cyc = 0;
    logic err_at_done = 1'b0;
    int wq_idx[$];
    int wq_dat[$];
    int wq_cyc[$];
    int hs_cyc[$];

    pea_cfg_loader dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .word_valid_i(word_valid_i), .word_i(word_i), .word_ready_o(word_ready_o),
        .cfg_we_o(cfg_we_o), .cfg_pe_idx_o(cfg_pe_idx_o), .cfg_data_o(cfg_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (cfg_we_o) begin
            wq_idx.push_back(int'(cfg_pe_idx_o));
            wq_dat.push_back(int'(cfg_data_o));
            wq_cyc.push_back(cyc);
        end
        if (word_valid_i && word_ready_o && !abort_i) hs_cyc.push_back(cyc);
        if (done_o) begin
            dones    <= dones + 1;
            done_cyc <= cyc;
            err_at_done <= err_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pe_data(input int i);
        return 16'((i << 8) | (i % 13));
    endfunction

    function automatic logic [31:0] mkword(input int k);
        return {pe_data(2 * k + 1), pe_data(2 * k)};
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        word_valid_i = 1'b1;
        word_i = w;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            ok = word_ready_o;
        end
        chk("send_ready", 32'(ok), 32'd1);
        tick();
        word_valid_i = 1'b0;
    endtask

    task automatic wait_done;
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_i);
            ok = done_o;
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int b, h, d;
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; word_valid_i = 1'b0; word_i = '0;
        #12;
        chk("rst_we", 32'(cfg_we_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_ready", 32'(word_ready_o), 0);
        chk("rst_idx", 32'(cfg_pe_idx_o), 0);
        chk("rst_data", 32'(cfg_data_o), 0);
        tick();
        rst_n_i = 1'b1;
        tick();

        // Full load
        b = wq_idx.size(); h = hs_cyc.size(); d = dones;
        pulse_start();
        chk("start_busy", 32'(busy_o), 1);
        chk("wait_ready", 32'(word_ready_o), 1);
        for (int k = 0; k < 8; k++) send_word(mkword(k));
        wait_done();
        tick();
        chk("full_count", 32'(wq_idx.size() - b), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("full_idx%0d", i), 32'(wq_idx[b + i]), 32'(i));
            chk($sformatf("full_dat%0d", i), 32'(wq_dat[b + i]), 32'(pe_data(i)));
        end
        chk("full_dones", 32'(dones - d), 1);
        chk("lat_lo", 32'(wq_cyc[b] - hs_cyc[h]), 1);
        chk("lat_hi", 32'(wq_cyc[b + 1] - hs_cyc[h]), 2);
        chk("rate", 32'(hs_cyc[h + 1] - hs_cyc[h]), 3);
        chk("done_lat", 32'(done_cyc - wq_cyc[b + 15]), 1);
        chk("full_err", 32'(err_o), 0);
        chk("idle_busy", 32'(busy_o), 0);

        // Backpressure plus illegal opcode at PE5
        b = wq_idx.size(); d = dones;
        pulse_start();
        send_word(mkword(0));
        send_word(mkword(1));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_ready", 32'(word_ready_o), 1);
            chk("bp_we", 32'(cfg_we_o), 0);
        end
        tick();
        send_word(32'h000D_0000);
        for (int k = 3; k < 8; k++) send_word(mkword(k));
        wait_done();
        tick();
        chk("ill_count", 32'(wq_idx.size() - b), 15);
        chk("ill_idx4", 32'(wq_idx[b + 4]), 4);
        chk("ill_dat4", 32'(wq_dat[b + 4]), 0);
        chk("ill_idx5", 32'(wq_idx[b + 5]), 6);
        chk("ill_idx_last", 32'(wq_idx[b + 14]), 15);
        chk("ill_err_done", 32'(err_at_done), 1);
        chk("ill_err_hold", 32'(err_o), 1);
        chk("ill_dones", 32'(dones - d), 1);

        // Abort in HI of word 3
        b = wq_idx.size(); d = dones;
        pulse_start();
        chk("err_clear", 32'(err_o), 0);
        for (int k = 0; k < 4; k++) send_word(mkword(k));
        tick();
        abort_i = 1'b1;
        @(negedge clk_i);
        chk("abort_we", 32'(cfg_we_o), 0);
        chk("abort_done", 32'(done_o), 0);
        tick();
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_idle", 32'(busy_o), 0);
        repeat (3) tick();
        chk("abort_count", 32'(wq_idx.size() - b), 7);
        chk("abort_last", 32'(wq_idx[wq_idx.size() - 1]), 6);
        chk("abort_dones", 32'(dones - d), 0);

        // Fresh load with start held high throughout
        b = wq_idx.size(); d = dones;
        start_i = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) send_word(mkword(k));
        wait_done();
        start_i = 1'b0;
        tick();
        tick();
        chk("hold_busy", 32'(busy_o), 0);
        chk("hold_count", 32'(wq_idx.size() - b), 16);
        chk("hold_first", 32'(wq_idx[b]), 0);
        chk("hold_last", 32'(wq_idx[b + 15]), 15);
        chk("hold_dones", 32'(dones - d), 1);

        // Async reset while in LO
        pulse_start();
        send_word(mkword(0));
        #1;
        chk("lo_we", 32'(cfg_we_o), 1);
        rst_n_i = 1'b0;
        #1;
        chk("arst_we", 32'(cfg_we_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_idx", 32'(cfg_pe_idx_o), 0);
        chk("arst_data", 32'(cfg_data_o), 0);
        tick();
        rst_n_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
